// File: rtl/dar_pkg.sv
// Shared constants and FSM state type for the dar_master register-port initiator.
package dar_pkg;

    localparam int DAR_DATA_W = 8;
    localparam int DAR_ADDR_W = 2;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RSP      = 3'd4,
        ST_SWEEP_WR = 3'd5,
        ST_SWEEP_RD = 3'd6
    } dar_state_e;

endpackage

// File: rtl/dar_master_if.sv
// Command, response and register-port bundle between a controller, dar_master and the register file.
interface dar_master_if import dar_pkg::*; #(
    parameter int DATA_W = DAR_DATA_W,
    parameter int ADDR_W = DAR_ADDR_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              reg_w_en;
    logic              reg_r_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, reg_rdata,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, busy,
               reg_w_en, reg_r_en, reg_addr, reg_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, reg_rdata,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, busy,
               reg_w_en, reg_r_en, reg_addr, reg_wdata
    );

endinterface

// File: rtl/dar_rd_lat_ctr.sv
// Read-latency down-counter: loaded on the read-issue cycle, done when read data is valid.
module dar_rd_lat_ctr #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [1:0] LOAD_VAL = 2'(RD_LAT - 1);

    logic [1:0] cnt_r;

    // Load on issue, then count down to zero and hold there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 2'd0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 2'd0);

endmodule

// File: rtl/dar_master.sv
// Register-file port initiator: write, read, clear-all and dump commands with read responses.
// Optional write-verify read-back is enabled by defining DAR_MASTER_WVERIFY_EN.
module dar_master import dar_pkg::*; #(
    parameter int DATA_W = DAR_DATA_W,
    parameter int ADDR_W = DAR_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    dar_master_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    dar_state_e        state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              sweep_r, sweep_s;
    logic              lat_done_s, capture_s;
    logic              w_en_s, r_en_s;
    logic [ADDR_W-1:0] reg_addr_s;
    logic [DATA_W-1:0] reg_wdata_s;

    logic              cmd_ready_r, busy_r, rsp_valid_r, rsp_err_r;
    logic              reg_w_en_r, reg_r_en_r;
    logic [ADDR_W-1:0] reg_addr_r, rsp_addr_r;
    logic [DATA_W-1:0] reg_wdata_r, rsp_data_r;

`ifdef DAR_MASTER_WVERIFY_EN
    logic              verify_r, verify_s;
`endif

    dar_rd_lat_ctr #(.RD_LAT(RD_LAT)) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (state_r == ST_RD_ISSUE),
        .done (lat_done_s)
    );

    assign capture_s = (state_r == ST_RD_WAIT) && lat_done_s;

    // Next-state logic; addr_r doubles as the sweep index during clear-all and dump.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        sweep_s = sweep_r;
`ifdef DAR_MASTER_WVERIFY_EN
        verify_s = verify_r;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef DAR_MASTER_WVERIFY_EN
                verify_s = 1'b0;
`endif
                if (bus.cmd_valid) begin
                    addr_s  = bus.cmd_addr;
                    wdata_s = bus.cmd_wdata;
                    sweep_s = 1'b0;
                    case (bus.cmd_op)
                        OP_WR:   state_s = ST_WR;
                        OP_RD:   state_s = ST_RD_ISSUE;
                        OP_CLR:  begin state_s = ST_SWEEP_WR; addr_s = '0; end
                        OP_DUMP: begin state_s = ST_RD_ISSUE; addr_s = '0; sweep_s = 1'b1; end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
`ifdef DAR_MASTER_WVERIFY_EN
                state_s  = ST_RD_ISSUE;
                verify_s = 1'b1;
`else
                state_s  = ST_IDLE;
`endif
            end
            ST_RD_ISSUE: state_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (lat_done_s) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_RSP: begin
                if (!bus.rsp_ready) begin
                    state_s = ST_RSP;
                end else if (sweep_r && (addr_r != ADDR_LAST)) begin
                    addr_s  = addr_r + 1'b1;
                    state_s = ST_RD_ISSUE;
                end else begin
                    sweep_s = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP_WR: begin
                if (addr_r == ADDR_LAST) begin
                    addr_s  = '0;
                    state_s = ST_IDLE;
                end else begin
                    addr_s  = addr_r + 1'b1;
                    state_s = ST_SWEEP_WR;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Port outputs are decoded from the next state so they register in step with it.
        w_en_s      = (state_s == ST_WR) || (state_s == ST_SWEEP_WR);
        r_en_s      = (state_s == ST_RD_ISSUE);
        reg_addr_s  = (w_en_s || r_en_s) ? addr_s : '0;
        reg_wdata_s = (state_s == ST_WR) ? wdata_s : '0;
    end

    // State, working registers and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            sweep_r     <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            reg_w_en_r  <= 1'b0;
            reg_r_en_r  <= 1'b0;
            reg_addr_r  <= '0;
            reg_wdata_r <= '0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            sweep_r     <= sweep_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            rsp_valid_r <= (state_s == ST_RSP);
            reg_w_en_r  <= w_en_s;
            reg_r_en_r  <= r_en_s;
            reg_addr_r  <= reg_addr_s;
            reg_wdata_r <= reg_wdata_s;
        end
    end

    // Response payload is captured once and held until the next read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_r <= '0;
            rsp_addr_r <= '0;
            rsp_err_r  <= 1'b0;
        end else if (capture_s) begin
            rsp_data_r <= bus.reg_rdata;
            rsp_addr_r <= addr_r;
`ifdef DAR_MASTER_WVERIFY_EN
            rsp_err_r  <= verify_r && (bus.reg_rdata != wdata_r);
`else
            rsp_err_r  <= 1'b0;
`endif
        end
    end

`ifdef DAR_MASTER_WVERIFY_EN
    // Marks the read that follows a single write as a verify read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_r <= 1'b0;
        end else begin
            verify_r <= verify_s;
        end
    end
`endif

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_addr  = rsp_addr_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.reg_w_en  = reg_w_en_r;
    assign bus.reg_r_en  = reg_r_en_r;
    assign bus.reg_addr  = reg_addr_r;
    assign bus.reg_wdata = reg_wdata_r;

endmodule
